// File: rtl/sdram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdram_pkg                                                                  |
// | State encoding and sizing helpers shared by the SDRAM behavioural model.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package sdram_pkg;

    typedef enum logic [2:0] {
        SDR_IDLE     = 3'd0,
        SDR_WR_WAIT  = 3'd1,
        SDR_WR_DONE  = 3'd2,
        SDR_RD_WAIT  = 3'd3,
        SDR_RD_BURST = 3'd4
    } sdr_state_t;

    function automatic int sdr_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    // The latency counter only has to reach LAT-2, i.e. LAT-1 distinct values.
    function automatic int sdr_lat_cnt_w(input int lat);
        return (lat > 2) ? sdr_clog2(lat - 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_byte_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdram_byte_array                                                           |
// | Byte-lane memory: word read port, masked word write port, big-endian lanes.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sdram_byte_array
    import sdram_pkg::*;
#(
    parameter int MEM_SIZE = 65536,
    parameter int AWIDTH   = 25,
    parameter int DWIDTH   = 32
) (
    input  logic                  clk_i,
    input  logic [AWIDTH-1:0]     rd_addr_i,
    output logic [DWIDTH-1:0]     rd_data_o,
    input  logic                  wr_en_i,
    input  logic [AWIDTH-1:0]     wr_addr_i,
    input  logic [DWIDTH-1:0]     wr_data_i,
    input  logic [DWIDTH/8-1:0]   wr_be_i
);

    localparam int c_bytes = DWIDTH / 8;
    localparam int c_mw    = sdr_clog2(MEM_SIZE);

    logic [7:0]      mem_q    [MEM_SIZE];
    logic [c_mw-1:0] w_rd_idx [c_bytes];
    logic [c_mw-1:0] w_wr_idx [c_bytes];

    // Each lane wraps on its own, so a word straddling the top of memory still maps correctly.
    for (genvar i = 0; i < c_bytes; i++) begin : g_lane
        assign w_rd_idx[i] = c_mw'(rd_addr_i + AWIDTH'(i));
        assign w_wr_idx[i] = c_mw'(wr_addr_i + AWIDTH'(i));
        assign rd_data_o[DWIDTH-1-8*i -: 8] = mem_q[w_rd_idx[i]];
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < c_bytes; i++) begin
            if (wr_en_i && wr_be_i[c_bytes-1-i]) begin
                mem_q[w_wr_idx[i]] <= wr_data_i[DWIDTH-1-8*i -: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_burst_model.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdram_burst_model                                                          |
// | Behavioural SDRAM: req/ack, byte-enable writes, latency, read bursts.      |
// | Optional SDRAM_MODEL_ERR_EN adds a sticky err_o for range/length faults.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sdram_burst_model
    import sdram_pkg::*;
#(
    parameter int MEM_SIZE  = 65536,
    parameter int AWIDTH    = 25,
    parameter int DWIDTH    = 32,
    parameter int WR_LAT    = 2,
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_req_i,
    input  logic                          rd_req_i,
    input  logic [AWIDTH-1:0]             addr_i,
    input  logic [DWIDTH-1:0]             wr_data_i,
    input  logic [DWIDTH/8-1:0]           wr_be_i,
    input  logic [sdr_clog2(MAX_BURST):0] rd_len_i,
    output logic                          wr_ack_o,
    output logic                          rd_ack_o,
    output logic                          rd_valid_o,
    output logic [DWIDTH-1:0]             rd_data_o,
    output logic                          busy_o
`ifdef SDRAM_MODEL_ERR_EN
    ,
    output logic                          err_o
`endif
);

    localparam int c_bytes = DWIDTH / 8;
    localparam int c_lw    = sdr_clog2(MAX_BURST) + 1;
    localparam int c_cw    = sdr_lat_cnt_w((WR_LAT > RD_LAT) ? WR_LAT : RD_LAT);
    localparam logic [c_lw-1:0]   c_max_len = c_lw'(MAX_BURST);
    localparam logic [c_cw-1:0]   c_wr_last = c_cw'((WR_LAT > 1) ? WR_LAT - 2 : 0);
    localparam logic [c_cw-1:0]   c_rd_last = c_cw'((RD_LAT > 1) ? RD_LAT - 2 : 0);
    localparam logic [AWIDTH-1:0] c_step    = AWIDTH'(c_bytes);
    localparam logic [AWIDTH-1:0] c_align   = ~(AWIDTH'(c_bytes - 1));

    sdr_state_t          state_q;
    logic [c_cw-1:0]     cnt_q;
    logic [AWIDTH-1:0]   addr_q;
    logic [DWIDTH-1:0]   wdata_q;
    logic [c_bytes-1:0]  be_q;
    logic [c_lw-1:0]     beats_q;
    logic                wr_ack_q;
    logic                rd_ack_q;
    logic                rd_valid_q;
    logic [DWIDTH-1:0]   rd_data_q;

    logic [AWIDTH-1:0]   w_base;
    logic [AWIDTH-1:0]   w_rd_addr;
    logic [c_lw-1:0]     w_len;
    logic [c_lw-1:0]     w_beats;
    logic [DWIDTH-1:0]   w_mem_rdata;
    logic                w_wr_en;
    logic                w_load_beat;

    assign w_base  = addr_i & c_align;
    assign w_len   = (rd_len_i == '0) ? c_lw'(1) : ((rd_len_i > c_max_len) ? c_max_len : rd_len_i);
    assign w_wr_en = (state_q == SDR_WR_DONE);

    // beats_q counts beats still to be fetched; from IDLE (RD_LAT==1) the request itself supplies them.
    assign w_rd_addr   = (state_q == SDR_IDLE) ? w_base : addr_q;
    assign w_beats     = (state_q == SDR_IDLE) ? w_len  : beats_q;
    assign w_load_beat = (state_q == SDR_IDLE && !wr_req_i && rd_req_i && RD_LAT == 1)
                      || (state_q == SDR_RD_WAIT && cnt_q == c_rd_last)
                      || (state_q == SDR_RD_BURST && beats_q != '0);

    sdram_byte_array #(
        .MEM_SIZE (MEM_SIZE),
        .AWIDTH   (AWIDTH),
        .DWIDTH   (DWIDTH)
    ) u_array (
        .clk_i     (clk_i),
        .rd_addr_i (w_rd_addr),
        .rd_data_o (w_mem_rdata),
        .wr_en_i   (w_wr_en),
        .wr_addr_i (addr_q),
        .wr_data_i (wdata_q),
        .wr_be_i   (be_q)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= SDR_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            beats_q    <= '0;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state_q)
                SDR_IDLE: begin
                    cnt_q <= '0;
                    if (wr_req_i) begin
                        addr_q  <= w_base;
                        wdata_q <= wr_data_i;
                        be_q    <= wr_be_i;
                        if (WR_LAT == 1) begin
                            state_q  <= SDR_WR_DONE;
                            wr_ack_q <= 1'b1;
                        end else begin
                            state_q <= SDR_WR_WAIT;
                        end
                    end else if (rd_req_i) begin
                        addr_q  <= w_base;
                        beats_q <= w_len;
                        state_q <= SDR_RD_WAIT;
                    end
                end
                SDR_WR_WAIT: begin
                    if (cnt_q == c_wr_last) begin
                        state_q  <= SDR_WR_DONE;
                        wr_ack_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + c_cw'(1);
                    end
                end
                SDR_WR_DONE:  state_q <= SDR_IDLE;
                SDR_RD_WAIT:  cnt_q   <= cnt_q + c_cw'(1);
                SDR_RD_BURST: state_q <= SDR_IDLE;
                default:      state_q <= SDR_IDLE;
            endcase
            // Beat fetch overrides the per-state next values above.
            if (w_load_beat) begin
                state_q    <= SDR_RD_BURST;
                addr_q     <= w_rd_addr + c_step;
                beats_q    <= w_beats - c_lw'(1);
                rd_data_q  <= w_mem_rdata;
                rd_valid_q <= 1'b1;
                rd_ack_q   <= (w_beats == c_lw'(1));
            end
        end
    end

    assign wr_ack_o   = wr_ack_q;
    assign rd_ack_o   = rd_ack_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign busy_o     = (state_q != SDR_IDLE);

`ifdef SDRAM_MODEL_ERR_EN
    localparam int c_mw = sdr_clog2(MEM_SIZE);

    logic err_q;
    logic w_bad_addr;

    assign w_bad_addr = (addr_i >> c_mw) != '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (state_q == SDR_IDLE) begin
            if (wr_req_i) begin
                err_q <= err_q | w_bad_addr;
            end else if (rd_req_i) begin
                err_q <= err_q | w_bad_addr | (rd_len_i > c_max_len);
            end
        end
    end

    assign err_o = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_burst_model.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sdram_burst_model                                                       |
// | Directed self-checking bench for sdram_burst_model (WR_LAT=RD_LAT=2).      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sdram_burst_model;

    localparam int MEM_SIZE = 65536;
    localparam int AW       = 25;
    localparam int DW       = 32;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          wr_req  = 1'b0;
    logic          rd_req  = 1'b0;
    logic [AW-1:0] addr    = '0;
    logic [DW-1:0] wr_data = '0;
    logic [3:0]    wr_be   = '0;
    logic [3:0]    rd_len  = '0;
    logic          wr_ack;
    logic          rd_ack;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          busy;
`ifdef SDRAM_MODEL_ERR_EN
    logic          err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] rb [16];
    int          rb_n;
    int          rb_first;
    int          rb_last;
    int          rb_ack_bad;
    bit          rb_ack_last;
    bit          rb_to;

    always #5 clk = ~clk;

    sdram_burst_model #(
        .MEM_SIZE  (MEM_SIZE),
        .AWIDTH    (AW),
        .DWIDTH    (DW),
        .WR_LAT    (2),
        .RD_LAT    (2),
        .MAX_BURST (8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_req_i   (wr_req),
        .rd_req_i   (rd_req),
        .addr_i     (addr),
        .wr_data_i  (wr_data),
        .wr_be_i    (wr_be),
        .rd_len_i   (rd_len),
        .wr_ack_o   (wr_ack),
        .rd_ack_o   (rd_ack),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data),
        .busy_o     (busy)
`ifdef SDRAM_MODEL_ERR_EN
        ,
        .err_o      (err)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Called at a negedge; returns lat = negedges from request to wr_ack.
    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be,
                            output int lat);
        addr = a; wr_data = d; wr_be = be; wr_req = 1'b1; lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) check("wr_busy", busy, 1);
            if (wr_ack) begin
                lat = n;
                break;
            end
        end
        wr_req = 1'b0;
        @(negedge clk);
    endtask

    // abort_after != 0 asserts rst right after that many beats have been seen.
    task automatic do_read(input logic [AW-1:0] a, input logic [3:0] len, input int abort_after);
        rb_n = 0; rb_first = -1; rb_last = -1; rb_ack_bad = 0; rb_ack_last = 1'b0; rb_to = 1'b1;
        addr = a; rd_len = len; rd_req = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (rd_valid) begin
                if (rb_n < 16) rb[rb_n] = rd_data;
                if (rb_first < 0) rb_first = n;
                rb_last = n;
                rb_n++;
                if (rd_ack) begin
                    rb_ack_last = 1'b1;
                    rb_to = 1'b0;
                    break;
                end
                if (abort_after != 0 && rb_n == abort_after) begin
                    rst = 1'b1;
                    rb_to = 1'b0;
                    break;
                end
            end else if (rd_ack) begin
                rb_ack_bad++;
            end
        end
        rd_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        int wa;
        int rf;
        bit to;
        logic [31:0] rdat;

        // Reset held with a write request pending
        wr_req = 1'b1; addr = 25'h10; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_wr_ack",   wr_ack,   0);
        check("rst_rd_ack",   rd_ack,   0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data",  rd_data,  0);
        check("rst_busy",     busy,     0);
`ifdef SDRAM_MODEL_ERR_EN
        check("rst_err",      err,      0);
`endif
        rst = 1'b0; wr_req = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Full-word write then single read
        do_write(25'h10, 32'hDEADBEEF, 4'hF, lat);
        check("wr_lat", lat, 2);
        do_read(25'h10, 4'd1, 0);
        check("rd_lat",   rb_first,    2);
        check("rd_beats", rb_n,        1);
        check("rd_data",  rb[0],       32'hDEADBEEF);
        check("rd_ack",   rb_ack_last, 1);
        check("rd_to",    rb_to,       0);

        // Byte enables: only lanes 2 and 0 (bytes 0x11 and 0x13) change
        do_write(25'h10, 32'h11223344, 4'b0101, lat);
        check("be_wr_lat", lat, 2);
        do_read(25'h10, 4'd1, 0);
        check("be_data", rb[0], 32'hDE22BE44);

        // Burst wrapping past the top of memory
        do_write(25'hFFF8, 32'hA0A1A2A3, 4'hF, lat);
        do_write(25'hFFFC, 32'hB0B1B2B3, 4'hF, lat);
        do_write(25'h0000, 32'hC0C1C2C3, 4'hF, lat);
        do_write(25'h0004, 32'hD0D1D2D3, 4'hF, lat);
        do_read(25'hFFF8, 4'd4, 0);
        check("burst_beats",  rb_n,             4);
        check("burst_consec", rb_last - rb_first, 3);
        check("burst_b0",     rb[0],            32'hA0A1A2A3);
        check("burst_b1",     rb[1],            32'hB0B1B2B3);
        check("burst_b2",     rb[2],            32'hC0C1C2C3);
        check("burst_b3",     rb[3],            32'hD0D1D2D3);
        check("burst_ack",    rb_ack_last,      1);
        check("burst_ack_early", rb_ack_bad,    0);

        // rd_len = 0 behaves as a single beat
        do_read(25'h10, 4'd0, 0);
        check("len0_beats", rb_n,  1);
        check("len0_data",  rb[0], 32'hDE22BE44);
`ifdef SDRAM_MODEL_ERR_EN
        check("err_clean", err, 0);
`endif

        // Out-of-range, unaligned address wraps to word 0x10
        do_read(25'h10013, 4'd1, 0);
        check("wrap_addr_data", rb[0], 32'hDE22BE44);
`ifdef SDRAM_MODEL_ERR_EN
        check("err_oor", err, 1);
`endif

        // Oversized length clamps to MAX_BURST
        do_read(25'hFFF8, 4'd15, 0);
        check("clamp_beats", rb_n,  8);
        check("clamp_b2",    rb[2], 32'hC0C1C2C3);
        check("clamp_ack",   rb_ack_last, 1);
`ifdef SDRAM_MODEL_ERR_EN
        check("err_sticky", err, 1);
`endif

        // Simultaneous write and read on one address: write first, read sees new data
        addr = 25'h40; wr_data = 32'h5A5A1234; wr_be = 4'hF; rd_len = 4'd1;
        wr_req = 1'b1; rd_req = 1'b1;
        wa = -1; rf = -1; rdat = '0; to = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (wr_ack) begin
                wa = n;
                wr_req = 1'b0;
            end
            if (rd_valid) begin
                rf = n;
                rdat = rd_data;
            end
            if (rd_ack) begin
                to = 1'b0;
                break;
            end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        @(negedge clk);
        check("sim_wr_ack_at", wa,   2);
        check("sim_rd_at",     rf,   5);
        check("sim_rd_data",   rdat, 32'h5A5A1234);
        check("sim_to",        to,   0);

        // Reset while the write is still waiting: memory must stay untouched
        addr = 25'h10; wr_data = 32'h0; wr_be = 4'hF; wr_req = 1'b1;
        @(negedge clk);
        check("wwait_busy", busy, 1);
        rst = 1'b1; wr_req = 1'b0;
        @(negedge clk);
        check("wabort_ack",  wr_ack, 0);
        check("wabort_busy", busy,   0);
`ifdef SDRAM_MODEL_ERR_EN
        check("err_cleared", err, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        do_read(25'h10, 4'd1, 0);
        check("wabort_mem", rb[0], 32'hDE22BE44);

        // Reset after beat 2 of a 4-beat burst
        do_read(25'hFFF8, 4'd4, 2);
        check("rabort_beats",    rb_n,     2);
        check("rabort_b1",       rb[1],    32'hB0B1B2B3);
        check("rabort_valid",    rd_valid, 0);
        check("rabort_ack",      rd_ack,   0);
        check("rabort_busy",     busy,     0);
        check("rabort_rd_data",  rd_data,  0);
        rst = 1'b0;
        @(negedge clk);
        do_read(25'hFFF8, 4'd2, 0);
        check("post_beats", rb_n,        2);
        check("post_b0",    rb[0],       32'hA0A1A2A3);
        check("post_b1",    rb[1],       32'hB0B1B2B3);
        check("post_ack",   rb_ack_last, 1);
        check("post_lat",   rb_first,    2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
